idiv_sequential: RTL and testbench
==================================

# idiv_sequential

Sequential unsigned integer divider, the inverse of the team's combinational 16x16 IMUL datapath: it takes a 2·WIDTH-bit dividend (the width of a multiplier product) and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and remainder. It uses restoring division, one quotient bit per clock, behind a start/busy/done handshake. It sits beside the multiplier in the arithmetic unit, so a product oResult can be fed back as iDividend.

## Interface
- WIDTH, 16, operand width; dividend is 2·WIDTH bits, quotient and remainder are WIDTH bits
- Clock  input  1  rising-edge clock, only clock in the block
- Reset  input  1  asynchronous, active-low reset
- iStart  input  1  request a division; sampled only in IDLE
- iDividend  input  2·WIDTH  unsigned dividend, captured on the accepting edge
- iDivisor  input  WIDTH  unsigned divisor, captured on the accepting edge
- oBusy  output  1  high while an operation is in progress (RUN)
- oDone  output  1  one-cycle pulse; results valid in this cycle
- oError  output  1  valid with oDone; high on divide-by-zero or quotient overflow
- oQuotient  output  WIDTH  quotient, held until the next accepted start
- oRemainder  output  WIDTH  remainder, held until the next accepted start

## Operation
- States: IDLE, RUN, DONE.
- Reset (Reset=0, asynchronous): state=IDLE, and all outputs, internal registers and the iteration counter go to 0.
- IDLE, iStart=1:
  - Capture the operands.
  - Error check: divisor==0, or iDividend[2W-1:W] >= iDivisor (quotient does not fit in WIDTH bits).
  - On error: go to DONE with oError=1, oQuotient={WIDTH{1}}, oRemainder=iDividend[W-1:0].
  - Otherwise: load partial remainder R (WIDTH+1 bits) = iDividend[2W-1:W], load quotient shift register Q = iDividend[W-1:0], clear the counter, go to RUN.
- IDLE, iStart=0: remain in IDLE; outputs hold their last values.
- RUN, each edge (one iteration):
  - Shift {R,Q} left by 1.
  - Compute trial = R − divisor (WIDTH+1 bits).
  - If trial is non-negative: R = trial and Q[0]=1; otherwise Q[0]=0.
  - Increment the counter.
  - After WIDTH iterations: register oQuotient=Q and oRemainder=R[W-1:0], set oError=0, go to DONE.
- DONE: oDone=1 for exactly one cycle, then unconditionally go to IDLE.
- iStart is ignored in RUN and DONE. Operands may change freely after the accepting edge without affecting the result.
- Arithmetic is strictly unsigned. No signed mode.
- Invariant on success: oQuotient·divisor + oRemainder == dividend, and oRemainder < divisor.

## Timing
- Reference: edge k is the rising edge that samples iStart=1 in IDLE.
- Normal operation:
  - oBusy is high after edges k through k+WIDTH−1 (WIDTH cycles).
  - The final iteration happens at edge k+WIDTH.
  - oDone is high in the cycle after edge k+WIDTH; results are valid from that cycle on.
  - Latency is start→done = WIDTH+1 edges (17 for WIDTH=16).
- Error operation: oDone is high in the cycle after edge k (latency 1), and oBusy never asserts.
- Back-to-back: the earliest next accept is edge k+WIDTH+2, because the DONE cycle returns to IDLE first.
- oBusy and oDone are never high in the same cycle.
- Reset mid-RUN: all state and outputs clear immediately, without waiting for the clock. The operation is discarded, and no oDone is produced after reset release.
- Every output is registered. There are no combinational paths from inputs to outputs.

## Test plan
- iDividend=20, iDivisor=5 (inverse of 4·5), iStart one cycle -> oBusy high for 16 cycles; oDone on the 17th edge with oQuotient=4, oRemainder=0, oError=0.
- iDividend=100, iDivisor=7 -> oQuotient=14, oRemainder=2. Change the operands to random values during RUN -> the result is unchanged.
- iDividend=32'hFFFE0001, iDivisor=16'hFFFF -> oQuotient=16'hFFFF, oRemainder=0 (the maximum legal quotient).
- iDivisor=0 with iDividend=1234 -> oDone one cycle after accept, oError=1, oQuotient=16'hFFFF, oRemainder=1234, oBusy never high.
- iDividend=32'h00050000, iDivisor=4 (overflow) -> oError=1 after 1 cycle. Then iDividend=32'h00030000, iDivisor=4 -> oQuotient=16'hC000, oRemainder=0.
- Hold iStart high continuously -> operations complete every 18 cycles. Assert Reset low at RUN cycle 8 -> oBusy=0 and all outputs 0 immediately, and no oDone until a new start.

Source files
------------

// File: rtl/idiv_sequential_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The divider connects to the slave side; the requester connects to the master side.
interface idiv_sequential_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, error, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, error, quotient, remainder
  );
endinterface

// File: rtl/idiv_sequential.sv
// Restoring unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
module idiv_sequential #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  idiv_sequential_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             error_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             op_err;
  logic             last_iter;

  // Extra top bit acts as the borrow flag of the trial subtraction.
  function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH:0]   r,
                                                 input logic [WIDTH-1:0] d);
    return {1'b0, r} - {2'b00, d};
  endfunction

  // Upper dividend half >= divisor means the quotient needs more than WIDTH bits.
  assign op_err    = (bus.divisor == '0) ||
                     (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  assign shifted = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
  assign trial   = trial_sub(shifted, div_r);

  always_comb begin
    rem_nxt = shifted;
    quo_nxt = {quo_r[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      rem_nxt = trial[WIDTH:0];
      quo_nxt = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = op_err ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.error     = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      div_r       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            div_r <= bus.divisor;
            if (op_err) begin
              error_q     <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= bus.dividend[WIDTH-1:0];
            end else begin
              rem_r <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
              quo_r <= bus.dividend[WIDTH-1:0];
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          rem_r <= rem_nxt;
          quo_r <= quo_nxt;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            quotient_q  <= quo_nxt;
            remainder_q <= rem_nxt[WIDTH-1:0];
            error_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idiv_sequential.sv
// Directed-vector bench for idiv_sequential: latency, results, error path,
// back-to-back throughput and asynchronous reset during RUN.
module tb_idiv_sequential;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   overlap = 0;

  always #5 clk = ~clk;

  idiv_sequential_if #(.WIDTH(16)) bus ();

  idiv_sequential #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] ds,
                        input bit scramble, input bit exp_err,
                        input logic [15:0] exp_q, input logic [15:0] exp_r);
    int lat;
    int bcnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = ds;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) begin
        bcnt++;
        if (scramble) begin
          bus.dividend = $urandom;
          bus.divisor  = 16'($urandom);
        end
      end
      @(posedge clk); #1;
    end
    check({tag, ".latency"}, lat, exp_err ? 32'd1 : 32'd17);
    check({tag, ".busy_cycles"}, bcnt, exp_err ? 32'd0 : 32'd16);
    check({tag, ".error"}, bus.error, {31'd0, exp_err});
    check({tag, ".quotient"}, bus.quotient, exp_q);
    check({tag, ".remainder"}, bus.remainder, exp_r);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".hold_q"}, bus.quotient, exp_q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, d2, nd, nb;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.error", bus.error, 0);
    check("rst.quotient", bus.quotient, 0);
    check("rst.remainder", bus.remainder, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("div20_5",    32'd20,        16'd5,      1'b0, 1'b0, 16'd4,     16'd0);
    run_op("div100_7",   32'd100,       16'd7,      1'b1, 1'b0, 16'd14,    16'd2);
    run_op("maxq",       32'hFFFE0001,  16'hFFFF,   1'b0, 1'b0, 16'hFFFF,  16'd0);
    run_op("divzero",    32'd1234,      16'd0,      1'b0, 1'b1, 16'hFFFF,  16'd1234);
    run_op("ovf5",       32'h00050000,  16'd4,      1'b0, 1'b1, 16'hFFFF,  16'd0);
    run_op("ovf_eq",     32'h00040000,  16'd4,      1'b0, 1'b1, 16'hFFFF,  16'd0);
    run_op("div30000_4", 32'h00030000,  16'd4,      1'b0, 1'b0, 16'hC000,  16'd0);
    run_op("edge3ffff",  32'h0003FFFF,  16'd4,      1'b0, 1'b0, 16'hFFFF,  16'd3);

    // start held high: accepts every 18 edges
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd20;
    bus.divisor  = 16'd5;
    d0 = -1; d1 = -1; d2 = -1; nd = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        if (nd == 0) d0 = c;
        else if (nd == 1) d1 = c;
        else if (nd == 2) d2 = c;
        nd++;
      end
    end
    bus.start = 1'b0;
    check("b2b.first_done", d0, 16);
    check("b2b.period1", d1 - d0, 18);
    check("b2b.period2", d2 - d1, 18);
    check("b2b.quotient", bus.quotient, 16'd4);
    repeat (20) @(posedge clk);

    // reset during the eighth RUN cycle
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("midrst.busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.busy", bus.busy, 0);
    check("midrst.done", bus.done, 0);
    check("midrst.error", bus.error, 0);
    check("midrst.quotient", bus.quotient, 0);
    check("midrst.remainder", bus.remainder, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    nb = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
      if (bus.busy) nb++;
    end
    check("midrst.no_done", nd, 0);
    check("midrst.no_busy", nb, 0);

    run_op("post_rst", 32'd100, 16'd7, 1'b0, 1'b0, 16'd14, 16'd2);

    check("busy_done_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
